dmem_port_arbiter: RTL and testbench

//  Shares the CPU's single-port synchronous data memory between two requesters: the CPU load/store

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/dmem_arb_starve_cnt.sv | 40 ++++
 rtl/dmem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory port arbiter: requester IDs and default sizing.
package dmem_arb_pkg;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating up-counter tracking how many consecutive cycles the debug port has lost
// arbitration. Clear has priority over increment; sat flags the counter sitting at LIMIT.
module dmem_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_W = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: clear on a debug grant, otherwise count losses up to LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_W)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == LIMIT_W);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port synchronous data memory between the CPU load/store unit and
// the debug/loader port. One access per cycle, read data returned one cycle after grant.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration instead of CPU priority
// with starvation override.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  nreset,

    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,

    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_req_we,
    input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,

    output logic                  dbg_starved
);

    logic                  starve_sat;
    logic                  any_grant;
    logic                  win_id;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  rsp_pend_q, rsp_pend_d;
    logic                  rsp_owner_q, rsp_owner_d;
`ifdef DMEM_ARB_RR_EN
    logic                  last_win_q, last_win_d;
`endif

    dmem_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk    (clk),
        .nreset (nreset),
        .inc    (dbg_req_valid && !dbg_req_ready),
        .clr    (dbg_req_ready),
        .sat    (starve_sat)
    );

    // grant decision; nothing is granted while reset is asserted
    always_comb begin
        cpu_req_ready = 1'b0;
        dbg_req_ready = 1'b0;
        if (nreset) begin
            if (cpu_req_valid && dbg_req_valid) begin
`ifdef DMEM_ARB_RR_EN
                dbg_req_ready = (last_win_q == REQ_CPU);
`else
                dbg_req_ready = starve_sat;
`endif
                cpu_req_ready = !dbg_req_ready;
            end else begin
                cpu_req_ready = cpu_req_valid;
                dbg_req_ready = dbg_req_valid;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    assign dbg_starved = 1'b0;
`else
    assign dbg_starved = starve_sat;
`endif

    assign any_grant = cpu_req_ready || dbg_req_ready;
    assign win_id    = dbg_req_ready ? REQ_DBG : REQ_CPU;

    // memory port mux: winner's payload, or hold the last address/data when idle
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_wd   = wd_q;
        if (dbg_req_ready) begin
            mem_we   = dbg_req_we;
            mem_addr = dbg_req_addr;
            mem_wd   = dbg_req_wdata;
        end else if (cpu_req_ready) begin
            mem_we   = cpu_req_we;
            mem_addr = cpu_req_addr;
            mem_wd   = cpu_req_wdata;
        end
    end

    // next-state for held payload, response pipeline and last winner
    always_comb begin
        addr_d      = mem_addr;
        wd_d        = mem_wd;
        rsp_pend_d  = any_grant && !mem_we;
        rsp_owner_d = any_grant ? win_id : rsp_owner_q;
`ifdef DMEM_ARB_RR_EN
        last_win_d  = any_grant ? win_id : last_win_q;
`endif
    end

    // state registers; reset drops any in-flight read
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            addr_q      <= '0;
            wd_q        <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= REQ_CPU;
`ifdef DMEM_ARB_RR_EN
            last_win_q  <= REQ_DBG;
`endif
        end else begin
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
`ifdef DMEM_ARB_RR_EN
            last_win_q  <= last_win_d;
`endif
        end
    end

    assign cpu_rsp_valid = rsp_pend_q && (rsp_owner_q == REQ_CPU);
    assign dbg_rsp_valid = rsp_pend_q && (rsp_owner_q == REQ_DBG);
    assign cpu_rsp_rdata = mem_rd;
    assign dbg_rsp_rdata = mem_rd;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a behavioural synchronous data memory.
module tb_dmem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          nreset;
    logic          cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_rsp_valid;
    logic [DW-1:0] cpu_rsp_rdata;
    logic          dbg_req_valid, dbg_req_ready, dbg_req_we;
    logic [AW-1:0] dbg_req_addr;
    logic [DW-1:0] dbg_req_wdata;
    logic          dbg_rsp_valid;
    logic [DW-1:0] dbg_rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          dbg_starved;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    dmem_port_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .dbg_req_valid (dbg_req_valid),
        .dbg_req_ready (dbg_req_ready),
        .dbg_req_we    (dbg_req_we),
        .dbg_req_addr  (dbg_req_addr),
        .dbg_req_wdata (dbg_req_wdata),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_rdata (dbg_rsp_rdata),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wd        (mem_wd),
        .mem_rd        (mem_rd),
        .dbg_starved   (dbg_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous single-port memory, read data valid the cycle after the address edge
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
        mem_rd <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        nreset = 1'b0;
        step();
        step();
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        idle_inputs();
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 5'd7;
        dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd8;
        step();
        @(negedge clk);
        checks++;
        if ({cpu_req_ready, dbg_req_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b exp=00", {cpu_req_ready, dbg_req_ready});
        end
        checks++;
        if ({cpu_rsp_valid, dbg_rsp_valid, mem_we, dbg_starved} !== 4'b0000) begin
            errors++; $display("FAIL reset_outs got=%b exp=0000",
                               {cpu_rsp_valid, dbg_rsp_valid, mem_we, dbg_starved});
        end
        step();
        nreset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_req_ready, dbg_req_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_first_grant got=%b exp=10", {cpu_req_ready, dbg_req_ready});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_store_load();
        apply_reset();
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 5'd3; cpu_req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({cpu_req_ready, mem_we, mem_addr, mem_wd} !== {1'b1, 1'b1, 5'd3, 32'hDEADBEEF}) begin
            errors++; $display("FAIL store_port got=%b/%b/%0d/%h exp=1/1/3/deadbeef",
                               cpu_req_ready, mem_we, mem_addr, mem_wd);
        end
        step();
        cpu_req_we = 1'b0; cpu_req_wdata = '0;
        @(negedge clk);
        checks++;
        if ({cpu_req_ready, mem_we, cpu_rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL load_grant got=%b exp=100", {cpu_req_ready, mem_we, cpu_rsp_valid});
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({cpu_rsp_valid, dbg_rsp_valid} !== 2'b10 || cpu_rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_rsp got=%b rdata=%h exp=10 rdata=deadbeef",
                               {cpu_rsp_valid, dbg_rsp_valid}, cpu_rsp_rdata);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 5'd3) begin
            errors++; $display("FAIL idle_hold got=we%b addr%0d exp=we0 addr3", mem_we, mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if ({cpu_rsp_valid, dbg_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL rsp_one_cycle got=%b exp=00", {cpu_rsp_valid, dbg_rsp_valid});
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd0; dbg_req_wdata = 32'hA5A50000;
        @(negedge clk);
        checks++;
        if ({dbg_req_ready, cpu_req_ready, mem_we} !== 3'b101) begin
            errors++; $display("FAIL dbg_store got=%b exp=101", {dbg_req_ready, cpu_req_ready, mem_we});
        end
        step();
        idle_inputs();
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 5'd1; cpu_req_wdata = 32'h12345678;
        step();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c < 4) begin
                if (c % 2 == 0) begin
                    dbg_req_valid = 1'b1; dbg_req_addr = 5'd0;
                end else begin
                    cpu_req_valid = 1'b1; cpu_req_addr = 5'd1;
                end
            end
            @(negedge clk);
            if (c < 4) begin
                checks++;
                if ({cpu_req_ready, dbg_req_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL b2b_grant c=%0d got=%b", c, {cpu_req_ready, dbg_req_ready});
                end
            end
            if (c >= 1) begin
                checks++;
                if ((c - 1) % 2 == 0) begin
                    if ({cpu_rsp_valid, dbg_rsp_valid} !== 2'b01 || dbg_rsp_rdata !== 32'hA5A50000) begin
                        errors++; $display("FAIL b2b_rsp c=%0d got=%b rdata=%h exp=01 rdata=a5a50000",
                                           c, {cpu_rsp_valid, dbg_rsp_valid}, dbg_rsp_rdata);
                    end
                end else begin
                    if ({cpu_rsp_valid, dbg_rsp_valid} !== 2'b10 || cpu_rsp_rdata !== 32'h12345678) begin
                        errors++; $display("FAIL b2b_rsp c=%0d got=%b rdata=%h exp=10 rdata=12345678",
                                           c, {cpu_rsp_valid, dbg_rsp_valid}, cpu_rsp_rdata);
                    end
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_starve();
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            if (c < 6) begin
                cpu_req_valid = 1'b1; cpu_req_addr = 5'd1;
                dbg_req_valid = 1'b1; dbg_req_addr = 5'd0;
            end
            @(negedge clk);
            if (c < 6) begin
                checks++;
                if ({cpu_req_ready, dbg_req_ready, dbg_starved} !== ((c == 4) ? 3'b011 : 3'b100)) begin
                    errors++; $display("FAIL starve c=%0d got=%b exp=%b", c,
                                       {cpu_req_ready, dbg_req_ready, dbg_starved},
                                       (c == 4) ? 3'b011 : 3'b100);
                end
            end
            if (c == 5) begin
                checks++;
                if ({cpu_rsp_valid, dbg_rsp_valid} !== 2'b01 || dbg_rsp_rdata !== 32'hA5A50000) begin
                    errors++; $display("FAIL starve_rsp got=%b rdata=%h exp=01 rdata=a5a50000",
                                       {cpu_rsp_valid, dbg_rsp_valid}, dbg_rsp_rdata);
                end
            end
            if (c == 6) begin
                checks++;
                if ({cpu_rsp_valid, dbg_rsp_valid} !== 2'b10 || cpu_rsp_rdata !== 32'h12345678) begin
                    errors++; $display("FAIL starve_cpu_rsp got=%b rdata=%h exp=10 rdata=12345678",
                                       {cpu_rsp_valid, dbg_rsp_valid}, cpu_rsp_rdata);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        cpu_req_valid = 1'b1; cpu_req_addr = 5'd1;
        step();
        idle_inputs();
        nreset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_rsp_valid, dbg_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL mid_read_drop got=%b exp=00", {cpu_rsp_valid, dbg_rsp_valid});
        end
        step();
        nreset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_rsp_valid, dbg_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL post_reset_quiet got=%b exp=00", {cpu_rsp_valid, dbg_rsp_valid});
        end
        step();
        cpu_req_valid = 1'b1; cpu_req_addr = 5'd3;
        @(negedge clk);
        checks++;
        if (cpu_req_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_grant got=%b exp=1", cpu_req_ready);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL post_reset_rsp got=%b rdata=%h exp=1 rdata=deadbeef",
                               cpu_rsp_valid, cpu_rsp_rdata);
        end
        step();
    endtask

`ifdef DMEM_ARB_RR_EN
    task automatic test_round_robin();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            cpu_req_valid = 1'b1; cpu_req_addr = 5'd1;
            dbg_req_valid = 1'b1; dbg_req_addr = 5'd0;
            @(negedge clk);
            checks++;
            if ({cpu_req_ready, dbg_req_ready, dbg_starved} !== ((c % 2 == 0) ? 3'b100 : 3'b010)) begin
                errors++; $display("FAIL rr c=%0d got=%b", c, {cpu_req_ready, dbg_req_ready, dbg_starved});
            end
            step();
        end
        idle_inputs();
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_store_load();
        test_back_to_back();
`ifndef DMEM_ARB_RR_EN
        test_starve();
`endif
        test_reset_mid_read();
`ifdef DMEM_ARB_RR_EN
        test_round_robin();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
